// File: rtl/gesture_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : gesture_encoder
//  Description : Turns a stream of 4-channel EMG ADC samples into a debounced
//                one-hot gesture code for the servo-side gesture decoder.
//                Each channel is rectified about mid-scale, smoothed by an
//                exponential moving average and thresholded.  The 4-bit
//                activity pattern is mapped to a gesture code once per frame.
//                A frame ends on the sample for channel 3.  The output changes
//                only after HOLD_FRAMES identical classifications in a row.
//  Ports       : clk              system clock
//                rst              synchronous active-high reset
//                sample_valid_i   sample_ch_i / sample_data_i valid this cycle
//                sample_ch_i      channel index of the sample (0..3)
//                sample_data_i    unsigned ADC code
//                gesture_o        debounced one-hot gesture code
//                gesture_valid_o  one-cycle pulse when gesture_o changes
//                active_mask_o    per-channel activity of the last frame
//                frame_done_o     one-cycle pulse per registered classification
//  Revision    : 1.0  initial release
// ============================================================================
module gesture_encoder #(
   parameter int DATA_W      = 12,
   parameter int MIDSCALE    = 2048,
   parameter int ALPHA_SHIFT = 4,
   parameter int THRESH      = 512,
   parameter int HOLD_FRAMES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid_i,
   input  logic [1:0]        sample_ch_i,
   input  logic [DATA_W-1:0] sample_data_i,
   output logic [7:0]        gesture_o,
   output logic              gesture_valid_o,
   output logic [3:0]        active_mask_o,
   output logic              frame_done_o
);

   localparam int                 c_ACC_W  = DATA_W + ALPHA_SHIFT;
   localparam logic [DATA_W-1:0]  c_MID    = DATA_W'(MIDSCALE);
   localparam logic [c_ACC_W-1:0] c_THRESH = c_ACC_W'(THRESH);
   localparam logic [7:0]         c_HOLD   = 8'(HOLD_FRAMES);
   localparam logic [7:0]         c_REST   = 8'h01;

   // Envelope accumulators, one per channel
   logic [c_ACC_W-1:0] env_acc_q [4];
   logic [c_ACC_W-1:0] env_acc_d [4];
   logic [c_ACC_W-1:0] w_decay   [4];

   logic [DATA_W-1:0]  w_rect;
   logic [3:0]         w_pattern;
   logic [7:0]         w_code;

   // Classification / debounce / output state
   logic               frame_end_q, frame_end_d;
   logic               frame_done_q, frame_done_d;
   logic [3:0]         active_mask_q, active_mask_d;
   logic [7:0]         cand_q, cand_d;
   logic [7:0]         stable_cnt_q, stable_cnt_d;
   logic [7:0]         gesture_q, gesture_d;
   logic               gesture_valid_q, gesture_valid_d;

   // Full-wave rectification about the zero-signal code
   always_comb begin
      w_rect = (sample_data_i >= c_MID) ? (sample_data_i - c_MID)
                                        : (c_MID - sample_data_i);
   end

   // EMA update and thresholding.  The envelope is acc >> ALPHA_SHIFT; the
   // comparison is done at accumulator width so no bits are discarded.  The
   // update is computed modulo 2^c_ACC_W: the true result always fits, so a
   // transient wrap in the add/subtract cancels out.
   always_comb begin
      w_pattern = '0;
      for (int i = 0; i < 4; i++) begin
         w_decay[i]   = env_acc_q[i] >> ALPHA_SHIFT;
         w_pattern[i] = (w_decay[i] > c_THRESH);
         env_acc_d[i] = env_acc_q[i];
         if (sample_valid_i && (sample_ch_i == 2'(i))) begin
            env_acc_d[i] = env_acc_q[i] + c_ACC_W'(w_rect) - w_decay[i];
         end
      end
   end

   // Activity pattern to one-hot gesture code
   always_comb begin
      case (w_pattern)
         4'b0000: w_code = 8'h01;
         4'b0001: w_code = 8'h02;
         4'b0010: w_code = 8'h04;
         4'b0100: w_code = 8'h08;
         4'b1000: w_code = 8'h10;
         4'b0011: w_code = 8'h20;
         4'b1100: w_code = 8'h40;
         default: w_code = 8'h80;
      endcase
   end

   // frame_end_q marks the cycle after a channel-3 capture.  The envelopes
   // seen then already include that sample, so classification happens here.
   // The output stage reads the debounce registers one edge later.
   always_comb begin
      frame_end_d     = sample_valid_i && (sample_ch_i == 2'd3);
      frame_done_d    = frame_end_q;
      active_mask_d   = active_mask_q;
      cand_d          = cand_q;
      stable_cnt_d    = stable_cnt_q;
      gesture_d       = gesture_q;
      gesture_valid_d = 1'b0;

      if (frame_end_q) begin
         active_mask_d = w_pattern;
         if (w_code == cand_q) begin
            stable_cnt_d = (stable_cnt_q == 8'hFF) ? 8'hFF : stable_cnt_q + 8'd1;
         end else begin
            cand_d       = w_code;
            stable_cnt_d = 8'd1;
         end
      end

      if ((stable_cnt_q >= c_HOLD) && (cand_q != gesture_q)) begin
         gesture_d       = cand_q;
         gesture_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            env_acc_q[i] <= '0;
         end
         frame_end_q     <= 1'b0;
         frame_done_q    <= 1'b0;
         active_mask_q   <= 4'b0000;
         cand_q          <= c_REST;
         stable_cnt_q    <= 8'd0;
         gesture_q       <= c_REST;
         gesture_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            env_acc_q[i] <= env_acc_d[i];
         end
         frame_end_q     <= frame_end_d;
         frame_done_q    <= frame_done_d;
         active_mask_q   <= active_mask_d;
         cand_q          <= cand_d;
         stable_cnt_q    <= stable_cnt_d;
         gesture_q       <= gesture_d;
         gesture_valid_q <= gesture_valid_d;
      end
   end

   assign gesture_o       = gesture_q;
   assign gesture_valid_o = gesture_valid_q;
   assign active_mask_o   = active_mask_q;
   assign frame_done_o    = frame_done_q;

endmodule
`default_nettype wire
